// File: rtl/led_pkg.sv
// Shared types, default sizing and frame bit-ordering helper for the LED frame scheduler.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH        = 16;
  localparam int DEFAULT_DIV          = 2;
  localparam int DEFAULT_LATCH_CYCLES = 2;
  localparam int MAX_WIDTH            = 64;

  // Swaps the two halves so that shifting the image out MSB-first sends the
  // low half first, then the high half, each MSB-first.
  function automatic logic [MAX_WIDTH-1:0] frame_order(input logic [MAX_WIDTH-1:0] data,
                                                       input int width);
    logic [MAX_WIDTH-1:0] mask;
    int half;
    half = width / 2;
    mask = (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
    return ((data >> half) | (data << half)) & mask;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from pointer+1 upward (wrapping) for the first active request.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index
);

  logic found;
  int   cand;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(pointer) + k) % NUM_REQ;
      if (enable && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/led_frame_scheduler.sv
// Arbitrates LED frames from several requesters and serialises each onto a
// shift-clock/data pair followed by an active-low latch strobe.
module led_frame_scheduler
  import led_pkg::*;
#(
  parameter int  NUM_REQ      = 2,
  parameter int  WIDTH        = DEFAULT_WIDTH,
  parameter int  DIV          = DEFAULT_DIV,
  parameter int  LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
  localparam int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     busy,
  output logic                     led_sclk,
  output logic                     led_data,
  output logic                     led_latch
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int PH_W  = $clog2(2 * DIV);
  localparam int LT_W  = $clog2(LATCH_CYCLES + 1);

  state_t             state_reg, state_next;
  logic [BIT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [PH_W-1:0]    phase_cnt_reg, phase_cnt_next;
  logic [LT_W-1:0]    latch_cnt_reg, latch_cnt_next;
  logic [WIDTH-1:0]   shifter_reg, shifter_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   grant_id_reg, grant_id_next;
  logic               busy_reg, busy_next;
  logic               sclk_reg, sclk_next;
  logic               latch_reg, latch_next;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_index;
  logic [WIDTH-1:0]   frames [NUM_REQ];
  logic [WIDTH-1:0]   sel_data;
  logic [WIDTH-1:0]   frame_image;
  logic               handshake, last_phase, last_bit, last_latch;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arbiter (
    .req     (req_valid),
    .pointer (ptr_reg),
    .enable  (state_reg == IDLE),
    .grant   (arb_grant),
    .index   (arb_index)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_frames
    assign frames[gi] = req_data[gi*WIDTH +: WIDTH];
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_data = sel_data | (frames[i] & {WIDTH{arb_grant[i]}});
    end
  end

  assign frame_image = WIDTH'(frame_order(MAX_WIDTH'(sel_data), WIDTH));
  assign handshake   = |arb_grant;
  assign last_phase  = (phase_cnt_reg == PH_W'(2 * DIV - 1));
  assign last_bit    = (bit_cnt_reg == BIT_W'(WIDTH - 1));
  assign last_latch  = (latch_cnt_reg == LT_W'(LATCH_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (handshake) state_next = SHIFT;
      SHIFT:   if (last_phase && last_bit) state_next = LATCH;
      LATCH:   if (last_latch) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // led_data is the shifter MSB, so it only moves when the image is loaded or shifted.
  always_comb begin
    bit_cnt_next   = bit_cnt_reg;
    phase_cnt_next = phase_cnt_reg;
    latch_cnt_next = latch_cnt_reg;
    shifter_next   = shifter_reg;
    ptr_next       = ptr_reg;
    grant_id_next  = grant_id_reg;
    busy_next      = busy_reg;
    sclk_next      = sclk_reg;
    latch_next     = latch_reg;
    case (state_reg)
      IDLE: begin
        if (handshake) begin
          shifter_next   = frame_image;
          grant_id_next  = arb_index;
          ptr_next       = arb_index;
          busy_next      = 1'b1;
          sclk_next      = 1'b0;
          bit_cnt_next   = '0;
          phase_cnt_next = '0;
        end
      end
      SHIFT: begin
        if (last_phase) begin
          phase_cnt_next = '0;
          sclk_next      = 1'b0;
          if (last_bit) begin
            latch_next     = 1'b0;
            latch_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
            shifter_next = {shifter_reg[WIDTH-2:0], 1'b0};
          end
        end else begin
          phase_cnt_next = phase_cnt_reg + PH_W'(1);
          if (phase_cnt_reg == PH_W'(DIV - 1)) sclk_next = 1'b1;
        end
      end
      LATCH: begin
        if (last_latch) begin
          latch_next = 1'b1;
          busy_next  = 1'b0;
        end else begin
          latch_cnt_next = latch_cnt_reg + LT_W'(1);
        end
      end
      default: begin
        busy_next  = 1'b0;
        sclk_next  = 1'b0;
        latch_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg   <= '0;
      phase_cnt_reg <= '0;
      latch_cnt_reg <= '0;
      shifter_reg   <= '0;
      ptr_reg       <= IDX_W'(NUM_REQ - 1);
      grant_id_reg  <= '0;
      busy_reg      <= 1'b0;
      sclk_reg      <= 1'b0;
      latch_reg     <= 1'b1;
    end else begin
      bit_cnt_reg   <= bit_cnt_next;
      phase_cnt_reg <= phase_cnt_next;
      latch_cnt_reg <= latch_cnt_next;
      shifter_reg   <= shifter_next;
      ptr_reg       <= ptr_next;
      grant_id_reg  <= grant_id_next;
      busy_reg      <= busy_next;
      sclk_reg      <= sclk_next;
      latch_reg     <= latch_next;
    end
  end

  assign req_ready = arb_grant;
  assign grant_id  = grant_id_reg;
  assign busy      = busy_reg;
  assign led_sclk  = sclk_reg;
  assign led_data  = shifter_reg[WIDTH-1];
  assign led_latch = latch_reg;

endmodule
